// File: rtl/brick_store_grid_if.sv
// Bus bundle between the brick store and its clients (game FSM, collider, renderer).
//
// Handshake: every request (start_load, rd_en, hit_en) is a single-cycle strobe
// sampled on the rising clock edge. There is no ready/backpressure: a request is
// either accepted in the current state or dropped. An accepted read answers with
// rd_valid exactly one cycle later; an accepted hit answers with hit_ack exactly
// one cycle later. Responses last one cycle and cannot be stalled.
interface brick_store_grid_if #(
  parameter int AW = 6,
  parameter int DW = 21,
  parameter int CW = 6
);
  logic          start_load;
  logic          loading;
  logic          load_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          hit_en;
  logic [AW-1:0] hit_addr;
  logic          hit_ack;
  logic [1:0]    hit_result;
  logic [CW-1:0] live_count;
  logic          all_cleared;
  logic [1:0]    state_dbg;

  modport master (
    output start_load, rd_en, rd_addr, hit_en, hit_addr,
    input  loading, load_done, rd_valid, rd_data, hit_ack, hit_result,
           live_count, all_cleared, state_dbg
  );

  modport slave (
    input  start_load, rd_en, rd_addr, hit_en, hit_addr,
    output loading, load_done, rd_valid, rd_data, hit_ack, hit_result,
           live_count, all_cleared, state_dbg
  );
endinterface

// File: rtl/brick_store_grid.sv
// Brick-field store: ROWS x COLS bricks {x, y, color, hp} in a register array.
// A load FSM writes one brick per cycle; a registered read port serves the
// renderer; a hit port damages and retires bricks and tracks the live count.
module brick_store_grid #(
  parameter int COLS       = 10,
  parameter int ROWS       = 6,
  parameter int COORD_W    = 8,
  parameter int X_STEP     = 16,
  parameter int Y_ORIGIN   = 8,
  parameter int Y_STEP     = 4,
  parameter int HP_W       = 2,
  parameter int TOUGH_ROWS = 2
) (
  input  logic          clock,
  input  logic          reset,
  brick_store_grid_if.slave bus
);
  localparam int N   = ROWS * COLS;
  localparam int AW  = $clog2(N);
  localparam int CW  = $clog2(N + 1);
  localparam int DW  = 2 * COORD_W + 3 + HP_W;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RWW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Load walkers: index, column/row wrap counters, running x/y and row-colour phase.
  logic [AW-1:0]      idx_q, idx_d;
  logic [CLW-1:0]     col_q, col_d;
  logic [RWW-1:0]     row_q, row_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [2:0]         phase_q, phase_d;

  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] mem_d [N];

  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          hit_ack_q, hit_ack_d;
  logic [1:0]    hit_result_q, hit_result_d;
  logic [CW-1:0] live_q, live_d;

  logic          loading;
  logic          load_last;
  logic          load_start;
  logic          rd_accept;
  logic          hit_accept;
  logic [DW-1:0] load_word;
  logic [2:0]    load_color;
  logic [HP_W-1:0] load_hp;
  logic [DW-1:0] hit_word;
  logic [HP_W-1:0] hit_hp;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start_load only matters outside LOAD; LOAD ends on the last index.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_load) state_d = S_LOAD;
      S_LOAD:  if (load_last)      state_d = S_READY;
      S_READY: if (bus.start_load) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded controls: which requests are accepted this cycle.
  always_comb begin
    loading    = (state_q == S_LOAD);
    load_last  = loading && (int'(idx_q) == N - 1);
    load_start = bus.start_load && (state_q != S_LOAD);
    rd_accept  = bus.rd_en && (state_q != S_LOAD);
    hit_accept = bus.hit_en && (state_q == S_READY);
  end

  // Load walkers advance every LOAD cycle; column wrap steps the row, y and colour phase.
  always_comb begin
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    if (load_start) begin
      idx_d   = '0;
      col_d   = '0;
      row_d   = '0;
      x_d     = '0;
      y_d     = COORD_W'(Y_ORIGIN);
      phase_d = '0;
    end else if (loading) begin
      idx_d = idx_q + AW'(1);
      if (int'(col_q) == COLS - 1) begin
        col_d   = '0;
        x_d     = '0;
        row_d   = row_q + RWW'(1);
        y_d     = y_q + COORD_W'(Y_STEP);
        phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
      end else begin
        col_d = col_q + CLW'(1);
        x_d   = x_q + COORD_W'(X_STEP);
      end
    end
  end

  // Brick word being laid down this LOAD cycle.
  always_comb begin
    case (phase_q)
      3'd0:    load_color = 3'b100;
      3'd1:    load_color = 3'b101;
      3'd2:    load_color = 3'b110;
      3'd3:    load_color = 3'b010;
      3'd4:    load_color = 3'b011;
      3'd5:    load_color = 3'b001;
      default: load_color = 3'b000;
    endcase
    load_hp   = (int'(row_q) < TOUGH_ROWS) ? HP_W'(2) : HP_W'(1);
    load_word = {x_q, y_q, load_color, load_hp};
  end

  // Storage, read port, hit port and live count. Reads see mem_q, so a same-cycle
  // hit on the read index returns the pre-hit word.
  always_comb begin
    mem_d        = mem_q;
    live_d       = live_q;
    rd_valid_d   = rd_accept;
    rd_data_d    = rd_data_q;
    hit_ack_d    = hit_accept;
    hit_result_d = 2'b00;
    hit_word     = '0;
    hit_hp       = '0;

    if (rd_accept) begin
      rd_data_d = (int'(bus.rd_addr) < N) ? mem_q[bus.rd_addr] : '0;
    end

    if (hit_accept && (int'(bus.hit_addr) < N)) begin
      hit_word = mem_q[bus.hit_addr];
      hit_hp   = hit_word[HP_W-1:0];
      if (hit_hp > HP_W'(1)) begin
        mem_d[bus.hit_addr] = {hit_word[DW-1:HP_W], hit_hp - HP_W'(1)};
        hit_result_d        = 2'b01;
      end else if (hit_hp == HP_W'(1)) begin
        // Retired brick keeps its position but loses colour and hp.
        mem_d[bus.hit_addr] = {hit_word[DW-1:HP_W+3], 3'b000, {HP_W{1'b0}}};
        hit_result_d        = 2'b10;
        if (live_q != '0) live_d = live_q - CW'(1);
      end
    end

    if (load_start) begin
      live_d = '0;
    end else if (loading) begin
      mem_d[idx_q] = load_word;
      if (load_last) live_d = CW'(N);
    end
  end

  // Datapath registers; reset clears storage and every registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      idx_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      hit_ack_q    <= 1'b0;
      hit_result_q <= 2'b00;
      live_q       <= '0;
    end else begin
      mem_q        <= mem_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      hit_ack_q    <= hit_ack_d;
      hit_result_q <= hit_result_d;
      live_q       <= live_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.loading     = loading;
    bus.load_done   = load_last && !reset;
    bus.rd_valid    = rd_valid_q;
    bus.rd_data     = rd_data_q;
    bus.hit_ack     = hit_ack_q;
    bus.hit_result  = hit_result_q;
    bus.live_count  = live_q;
    bus.all_cleared = (state_q == S_READY) && (live_q == '0);
    bus.state_dbg   = state_q;
  end
endmodule

// File: tb/tb_brick_store_grid.sv
// Bench for brick_store_grid: directed scenarios plus a randomized read/hit run,
// all checked against a behavioural model of the brick field.
module tb_brick_store_grid;
  localparam int COLS       = 10;
  localparam int ROWS       = 6;
  localparam int X_STEP     = 16;
  localparam int Y_ORIGIN   = 8;
  localparam int Y_STEP     = 4;
  localparam int TOUGH_ROWS = 2;
  localparam int N          = ROWS * COLS;
  localparam int AW         = 6;
  localparam int CW         = 6;
  localparam int DW         = 21;

  logic clock = 1'b0;
  logic reset = 1'b1;

  brick_store_grid_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  brick_store_grid dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int            hp_m [N];
  bit            loaded_m;
  int            live_m;
  logic [DW-1:0] last_rd_m;
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] exp_word(input int i);
    logic [7:0] x, y;
    logic [2:0] c;
    int row, col;
    if (i >= N || !loaded_m) return '0;
    row = i / COLS;
    col = i % COLS;
    x = 8'(col * X_STEP);
    y = 8'(Y_ORIGIN + row * Y_STEP);
    case (row % 6)
      0: c = 3'b100;
      1: c = 3'b101;
      2: c = 3'b110;
      3: c = 3'b010;
      4: c = 3'b011;
      default: c = 3'b001;
    endcase
    if (hp_m[i] == 0) c = 3'b000;
    return {x, y, c, 2'(hp_m[i])};
  endfunction

  function automatic int model_hit(input int i);
    if (i >= N || hp_m[i] == 0) return 0;
    if (hp_m[i] > 1) begin
      hp_m[i] = hp_m[i] - 1;
      return 1;
    end
    hp_m[i] = 0;
    if (live_m > 0) live_m = live_m - 1;
    return 2;
  endfunction

  task automatic model_load();
    loaded_m = 1'b1;
    for (int i = 0; i < N; i++) hp_m[i] = ((i / COLS) < TOUGH_ROWS) ? 2 : 1;
    live_m = N;
  endtask

  task automatic model_reset();
    loaded_m = 1'b0;
    for (int i = 0; i < N; i++) hp_m[i] = 0;
    live_m    = 0;
    last_rd_m = '0;
  endtask

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic do_read(input int addr, input string name);
    logic [DW-1:0] e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(addr);
    exp_q.push_back(exp_word(addr));
    @(negedge clock);
    bus.rd_en = 1'b0;
    e = exp_q.pop_front();
    last_rd_m = e;
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rd_valid: got %b expected 1", name, bus.rd_valid);
    end
    checks++;
    if (bus.rd_data !== e) begin
      errors++;
      $display("FAIL %s rd_data[%0d]: got %h expected %h", name, addr, bus.rd_data, e);
    end
  endtask

  task automatic do_hit(input int addr, input string name);
    int r;
    r = model_hit(addr);
    bus.hit_en   = 1'b1;
    bus.hit_addr = AW'(addr);
    @(negedge clock);
    bus.hit_en = 1'b0;
    checks++;
    if (bus.hit_ack !== 1'b1 || bus.hit_result !== 2'(r)) begin
      errors++;
      $display("FAIL %s hit[%0d]: got ack=%b res=%b expected ack=1 res=%0d",
               name, addr, bus.hit_ack, bus.hit_result, r);
    end
    checks++;
    if (bus.live_count !== CW'(live_m)) begin
      errors++;
      $display("FAIL %s live_count: got %0d expected %0d", name, bus.live_count, live_m);
    end
    checks++;
    if (bus.all_cleared !== (live_m == 0)) begin
      errors++;
      $display("FAIL %s all_cleared: got %b expected %b", name, bus.all_cleared, live_m == 0);
    end
  endtask

  // Full load with a stray start_load and a read issued mid-load, both of which must be ignored.
  task automatic do_load(input string name);
    int  cyc = 0;
    int  pulses = 0;
    int  done_at = -1;
    bit  rv = 1'b0;
    bus.start_load = 1'b1;
    @(negedge clock);
    bus.start_load = 1'b0;
    for (int k = 0; k < 200 && bus.loading === 1'b1; k++) begin
      cyc++;
      if (bus.load_done === 1'b1) begin
        pulses++;
        done_at = cyc;
      end
      bus.start_load = (cyc == 10);
      bus.rd_en      = (cyc == 20);
      bus.rd_addr    = '0;
      @(negedge clock);
      if (bus.rd_valid === 1'b1) rv = 1'b1;
    end
    bus.start_load = 1'b0;
    bus.rd_en      = 1'b0;
    model_load();
    checks++;
    if (cyc != N) begin
      errors++;
      $display("FAIL %s loading_cycles: got %0d expected %0d", name, cyc, N);
    end
    checks++;
    if (pulses != 1 || done_at != N) begin
      errors++;
      $display("FAIL %s load_done: got %0d pulses at cycle %0d expected 1 at %0d",
               name, pulses, done_at, N);
    end
    checks++;
    if (rv) begin
      errors++;
      $display("FAIL %s rd_during_load: got rd_valid=1 expected 0", name);
    end
    checks++;
    if (bus.live_count !== CW'(N) || bus.all_cleared !== 1'b0) begin
      errors++;
      $display("FAIL %s after_load: got live=%0d cleared=%b expected live=%0d cleared=0",
               name, bus.live_count, bus.all_cleared, N);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.start_load = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.hit_en     = 1'b0;
    bus.hit_addr   = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    checks++;
    if (bus.loading !== 1'b0 || bus.load_done !== 1'b0 || bus.rd_valid !== 1'b0 ||
        bus.rd_data !== '0 || bus.hit_ack !== 1'b0 || bus.hit_result !== 2'b00 ||
        bus.live_count !== '0 || bus.all_cleared !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got loading=%b done=%b rv=%b rd=%h ack=%b res=%b live=%0d clr=%b expected all 0",
               bus.loading, bus.load_done, bus.rd_valid, bus.rd_data, bus.hit_ack,
               bus.hit_result, bus.live_count, bus.all_cleared);
    end
    do_read(0, "reset_read");
    bus.hit_en   = 1'b1;
    bus.hit_addr = AW'(0);
    @(negedge clock);
    bus.hit_en = 1'b0;
    checks++;
    if (bus.hit_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_hit_ack: got %b expected 0", bus.hit_ack);
    end
  endtask

  task automatic test_load();
    do_load("load");
    do_read(0, "load_idx0");
    do_read(9, "load_idx9");
    do_read(59, "load_idx59");
  endtask

  task automatic test_hit_destroy();
    do_hit(20, "destroy20");
    do_read(20, "destroy20_rd");
  endtask

  task automatic test_back_to_back();
    int r1, r2;
    r1 = model_hit(3);
    bus.hit_en   = 1'b1;
    bus.hit_addr = AW'(3);
    @(negedge clock);
    r2 = model_hit(3);
    checks++;
    if (bus.hit_ack !== 1'b1 || bus.hit_result !== 2'(r1)) begin
      errors++;
      $display("FAIL b2b_first: got ack=%b res=%b expected ack=1 res=%0d", bus.hit_ack, bus.hit_result, r1);
    end
    @(negedge clock);
    bus.hit_en = 1'b0;
    checks++;
    if (bus.hit_ack !== 1'b1 || bus.hit_result !== 2'(r2)) begin
      errors++;
      $display("FAIL b2b_second: got ack=%b res=%b expected ack=1 res=%0d", bus.hit_ack, bus.hit_result, r2);
    end
    do_read(3, "b2b_rd");
  endtask

  task automatic test_miss();
    do_hit(20, "miss_dead");
    do_hit(63, "miss_range");
    do_read(63, "rd_range");
  endtask

  task automatic test_rd_hit_same();
    logic [DW-1:0] e;
    int r;
    e = exp_word(5);
    r = model_hit(5);
    bus.rd_en    = 1'b1;
    bus.rd_addr  = AW'(5);
    bus.hit_en   = 1'b1;
    bus.hit_addr = AW'(5);
    @(negedge clock);
    bus.rd_en  = 1'b0;
    bus.hit_en = 1'b0;
    last_rd_m  = e;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      errors++;
      $display("FAIL same_cycle_rd: got v=%b %h expected v=1 %h", bus.rd_valid, bus.rd_data, e);
    end
    checks++;
    if (bus.hit_result !== 2'(r)) begin
      errors++;
      $display("FAIL same_cycle_hit: got %b expected %0d", bus.hit_result, r);
    end
    do_read(5, "same_cycle_after");
  endtask

  task automatic test_random();
    bit rd, h;
    int ra, ha, r;
    logic [DW-1:0] e;
    for (int it = 0; it < 300; it++) begin
      rd = ($urandom_range(0, 1) == 1);
      h  = ($urandom_range(0, 2) == 0);
      ra = $urandom_range(0, 63);
      ha = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 63);
      if (rd) exp_q.push_back(exp_word(ra));
      r = h ? model_hit(ha) : 0;
      bus.rd_en    = rd;
      bus.rd_addr  = AW'(ra);
      bus.hit_en   = h;
      bus.hit_addr = AW'(ha);
      @(negedge clock);
      bus.rd_en  = 1'b0;
      bus.hit_en = 1'b0;
      e = rd ? exp_q.pop_front() : last_rd_m;
      last_rd_m = e;
      checks++;
      if (bus.rd_valid !== rd || bus.rd_data !== e) begin
        errors++;
        $display("FAIL rand_rd it=%0d addr=%0d: got v=%b %h expected v=%b %h",
                 it, ra, bus.rd_valid, bus.rd_data, rd, e);
      end
      checks++;
      if (bus.hit_ack !== h || bus.hit_result !== 2'(r)) begin
        errors++;
        $display("FAIL rand_hit it=%0d addr=%0d: got ack=%b res=%b expected ack=%b res=%0d",
                 it, ha, bus.hit_ack, bus.hit_result, h, r);
      end
      checks++;
      if (bus.live_count !== CW'(live_m) || bus.all_cleared !== (live_m == 0)) begin
        errors++;
        $display("FAIL rand_live it=%0d: got %0d clr=%b expected %0d clr=%b",
                 it, bus.live_count, bus.all_cleared, live_m, live_m == 0);
      end
    end
  endtask

  task automatic test_reload();
    do_load("reload");
    do_read(3, "reload_idx3");
    do_read(20, "reload_idx20");
  endtask

  task automatic test_reset_mid_load();
    int stray = 0;
    bus.start_load = 1'b1;
    @(negedge clock);
    bus.start_load = 1'b0;
    repeat (30) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (bus.load_done === 1'b1 || bus.loading === 1'b1) stray++;
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 70; k++) begin
      @(negedge clock);
      if (bus.load_done === 1'b1 || bus.loading === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_load: got %0d cycles with loading/load_done expected 0", stray);
    end
    checks++;
    if (bus.live_count !== '0 || bus.all_cleared !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got live=%0d clr=%b expected live=0 clr=0",
               bus.live_count, bus.all_cleared);
    end
    do_read(59, "abort_rd59");
  endtask

  task automatic test_clear_all();
    do_load("clear_load");
    for (int i = 0; i < N; i++) begin
      while (hp_m[i] > 0) do_hit(i, "clear_hit");
    end
    do_hit(0, "underflow_hit");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load();
    test_hit_destroy();
    test_back_to_back();
    test_miss();
    test_rd_hit_same();
    test_random();
    test_reload();
    test_reset_mid_load();
    test_clear_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
